// File: rtl/lock_pkg.sv
// Shared types and constants for the dual-core global lock arbiter.
package lock_pkg;
   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned CNT_W      = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_C0   = 2'b01;
   localparam logic [1:0] OWNER_C1   = 2'b10;
endpackage

// File: rtl/global_lock_arbiter_if.sv
// Core-side lock/global ports and RAM-side ports of the lock arbiter.
interface global_lock_arbiter_if
   import lock_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic              need_lock_0;
   logic              need_lock_1;
   logic [ADDR_W-1:0] gaddress_0;
   logic [DATA_W-1:0] gdata_0;
   logic              gwren_0;
   logic [ADDR_W-1:0] gaddress_1;
   logic [DATA_W-1:0] gdata_1;
   logic              gwren_1;
   logic              lock_0;
   logic              lock_1;
   logic [DATA_W-1:0] gq_0;
   logic [DATA_W-1:0] gq_1;
   logic [ADDR_W-1:0] address_a;
   logic [DATA_W-1:0] data_a;
   logic              wren_a;
   logic [DATA_W-1:0] q_a;
   logic [ADDR_W-1:0] address_b;
   logic [DATA_W-1:0] data_b;
   logic              wren_b;
   logic [DATA_W-1:0] q_b;
   logic [1:0]        owner;
   logic [CNT_W-1:0]  violation_cnt;
   logic              hold_timeout;

   modport slave (
      input  need_lock_0, need_lock_1,
      input  gaddress_0, gdata_0, gwren_0,
      input  gaddress_1, gdata_1, gwren_1,
      input  q_a, q_b,
      output lock_0, lock_1, gq_0, gq_1,
      output address_a, data_a, wren_a,
      output address_b, data_b, wren_b,
      output owner, violation_cnt, hold_timeout
   );

   modport master (
      output need_lock_0, need_lock_1,
      output gaddress_0, gdata_0, gwren_0,
      output gaddress_1, gdata_1, gwren_1,
      output q_a, q_b,
      input  lock_0, lock_1, gq_0, gq_1,
      input  address_a, data_a, wren_a,
      input  address_b, data_b, wren_b,
      input  owner, violation_cnt, hold_timeout
   );
endinterface

// File: rtl/global_lock_arbiter_sat_counter8.sv
// 8-bit counter with synchronous clear and saturating +0/+1/+2 increment.
module sat_counter8
   import lock_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic [1:0]       i_inc,
   output logic [CNT_W-1:0] o_count
);
   logic [CNT_W-1:0] r_count;
   logic [CNT_W:0]   w_sum;

   assign w_sum   = {1'b0, r_count} + (CNT_W+1)'(i_inc);
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (w_sum[CNT_W]) begin
         r_count <= '1;
      end else begin
         r_count <= w_sum[CNT_W-1:0];
      end
   end
endmodule

// File: rtl/global_lock_arbiter.sv
// Two-core round-robin lock arbiter with write-guarded forwarding to a dual-port global RAM.
module global_lock_arbiter
   import lock_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned HOLD_MAX = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   global_lock_arbiter_if.slave  bus
);
   state_e            r_state;
   state_e            w_next;
   logic              r_rr;
   logic              w_rr_next;

   logic [ADDR_W-1:0] r_address_a;
   logic [DATA_W-1:0] r_data_a;
   logic              r_wren_a;
   logic [ADDR_W-1:0] r_address_b;
   logic [DATA_W-1:0] r_data_b;
   logic              r_wren_b;

   logic              w_collide;
   logic              w_wr_a;
   logic              w_wr_b;
   logic [1:0]        w_viol_inc;
   logic              w_hold_clr;
   logic [CNT_W-1:0]  w_hold_cnt;
   logic [CNT_W-1:0]  w_viol_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_rr    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_rr    <= w_rr_next;
      end
   end

   // Release with a waiter hands off directly; the pointer then favours the releasing core.
   always_comb begin
      w_next    = r_state;
      w_rr_next = r_rr;
      case (r_state)
         IDLE: begin
            if (bus.need_lock_0 && bus.need_lock_1) begin
               w_next    = r_rr ? OWN1 : OWN0;
               w_rr_next = ~r_rr;
            end else if (bus.need_lock_0) begin
               w_next = OWN0;
            end else if (bus.need_lock_1) begin
               w_next = OWN1;
            end
         end
         OWN0: begin
            if (!bus.need_lock_0) begin
               if (bus.need_lock_1) begin
                  w_next    = OWN1;
                  w_rr_next = 1'b0;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         OWN1: begin
            if (!bus.need_lock_1) begin
               if (bus.need_lock_0) begin
                  w_next    = OWN0;
                  w_rr_next = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.lock_0 = (r_state == OWN1) & bus.need_lock_0;
   assign bus.lock_1 = (r_state == OWN0) & bus.need_lock_1;
   assign bus.gq_0   = bus.q_a;
   assign bus.gq_1   = bus.q_b;

   always_comb begin
      bus.owner = OWNER_NONE;
      case (r_state)
         OWN0:    bus.owner = OWNER_C0;
         OWN1:    bus.owner = OWNER_C1;
         default: bus.owner = OWNER_NONE;
      endcase
   end

   // Core 0 wins a same-address write collision while nobody holds the lock.
   assign w_collide  = bus.gwren_0 & (r_state == IDLE) & (bus.gaddress_0 == bus.gaddress_1);
   assign w_wr_a     = bus.gwren_0 & (r_state != OWN1);
   assign w_wr_b     = bus.gwren_1 & (r_state != OWN0) & ~w_collide;
   assign w_viol_inc = 2'((bus.gwren_0 & ~w_wr_a)) + 2'((bus.gwren_1 & ~w_wr_b));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_address_a <= '0;
         r_data_a    <= '0;
         r_wren_a    <= 1'b0;
         r_address_b <= '0;
         r_data_b    <= '0;
         r_wren_b    <= 1'b0;
      end else begin
         r_address_a <= bus.gaddress_0;
         r_data_a    <= bus.gdata_0;
         r_wren_a    <= w_wr_a;
         r_address_b <= bus.gaddress_1;
         r_data_b    <= bus.gdata_1;
         r_wren_b    <= w_wr_b;
      end
   end

   assign bus.address_a = r_address_a;
   assign bus.data_a    = r_data_a;
   assign bus.wren_a    = r_wren_a;
   assign bus.address_b = r_address_b;
   assign bus.data_b    = r_data_b;
   assign bus.wren_b    = r_wren_b;

   assign w_hold_clr = (w_next != r_state) | (r_state == IDLE);

   sat_counter8 u_hold_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_hold_clr),
      .i_inc   (2'd1),
      .o_count (w_hold_cnt)
   );

   sat_counter8 u_viol_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (1'b0),
      .i_inc   (w_viol_inc),
      .o_count (w_viol_cnt)
   );

   assign bus.violation_cnt = w_viol_cnt;
   assign bus.hold_timeout  = (r_state != IDLE) & (w_hold_cnt >= CNT_W'(HOLD_MAX));
endmodule

// File: tb/tb_global_lock_arbiter.sv
// Directed scoreboard bench for global_lock_arbiter (HOLD_MAX=4).
module tb_global_lock_arbiter;
   import lock_pkg::*;

   localparam int unsigned HOLD_MAX = 4;

   typedef enum int {
      S_OWNER, S_LOCK0, S_LOCK1, S_WREN_A, S_WREN_B, S_ADDR_A, S_DATA_A,
      S_ADDR_B, S_DATA_B, S_VCNT, S_HTO, S_GQ0, S_GQ1
   } sel_e;

   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;
   exp_t sb[$];

   global_lock_arbiter_if bus ();

   global_lock_arbiter #(.HOLD_MAX(HOLD_MAX)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] observe(sel_e s);
      case (s)
         S_OWNER:  return 32'(bus.owner);
         S_LOCK0:  return 32'(bus.lock_0);
         S_LOCK1:  return 32'(bus.lock_1);
         S_WREN_A: return 32'(bus.wren_a);
         S_WREN_B: return 32'(bus.wren_b);
         S_ADDR_A: return 32'(bus.address_a);
         S_DATA_A: return 32'(bus.data_a);
         S_ADDR_B: return 32'(bus.address_b);
         S_DATA_B: return 32'(bus.data_b);
         S_VCNT:   return 32'(bus.violation_cnt);
         S_HTO:    return 32'(bus.hold_timeout);
         S_GQ0:    return 32'(bus.gq_0);
         S_GQ1:    return 32'(bus.gq_1);
         default:  return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_v(input string tag, input sel_e s, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = s;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] obs;
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_cmp++;
         assert (obs === e.exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   // Registered results are compared just after the edge that produces them.
   task automatic tick();
      @(posedge clk);
      #2;
      drain();
   endtask

   task automatic settle();
      #1;
      drain();
   endtask

   initial begin
      n_cmp           = 0;
      n_mis           = 0;
      rst             = 1'b0;
      bus.need_lock_0 = 1'b1;
      bus.need_lock_1 = 1'b1;
      bus.gwren_0     = 1'b1;
      bus.gwren_1     = 1'b1;
      bus.gaddress_0  = 6'd1;
      bus.gaddress_1  = 6'd2;
      bus.gdata_0     = 32'hFFFF_FFFF;
      bus.gdata_1     = 32'hFFFF_FFFF;
      bus.q_a         = '0;
      bus.q_b         = '0;

      // Reset held with everything asserted
      tick();
      expect_v("rst_owner", S_OWNER, 32'd0);
      expect_v("rst_lock0", S_LOCK0, 32'd0);
      expect_v("rst_lock1", S_LOCK1, 32'd0);
      expect_v("rst_wren_a", S_WREN_A, 32'd0);
      expect_v("rst_wren_b", S_WREN_B, 32'd0);
      expect_v("rst_addr_a", S_ADDR_A, 32'd0);
      expect_v("rst_data_a", S_DATA_A, 32'd0);
      expect_v("rst_vcnt", S_VCNT, 32'd0);
      expect_v("rst_hto", S_HTO, 32'd0);
      tick();

      rst         = 1'b1;
      bus.gwren_0 = 1'b0;
      bus.gwren_1 = 1'b0;
      expect_v("rel_owner", S_OWNER, 32'd1);
      expect_v("rel_lock1", S_LOCK1, 32'd1);
      expect_v("rel_lock0", S_LOCK0, 32'd0);
      expect_v("rel_addr_a", S_ADDR_A, 32'd1);
      expect_v("rel_wren_a", S_WREN_A, 32'd0);
      tick();
      bus.need_lock_0 = 1'b0;
      bus.need_lock_1 = 1'b0;
      expect_v("rel_idle", S_OWNER, 32'd0);
      tick();

      // Combinational read pass-through
      bus.q_a = 32'h1234_5678;
      bus.q_b = 32'h9ABC_DEF0;
      expect_v("gq0", S_GQ0, 32'h1234_5678);
      expect_v("gq1", S_GQ1, 32'h9ABC_DEF0);
      settle();

      // Single grant, stall of waiter, direct hand-off
      bus.need_lock_0 = 1'b1;
      expect_v("grant0", S_OWNER, 32'd1);
      tick();
      bus.need_lock_1 = 1'b1;
      expect_v("wait_lock1", S_LOCK1, 32'd1);
      expect_v("wait_lock0", S_LOCK0, 32'd0);
      settle();
      bus.need_lock_0 = 1'b0;
      expect_v("pre_hand_lock1", S_LOCK1, 32'd1);
      settle();
      expect_v("hand_owner", S_OWNER, 32'd2);
      expect_v("hand_lock1", S_LOCK1, 32'd0);
      expect_v("hand_lock0", S_LOCK0, 32'd0);
      tick();
      bus.need_lock_1 = 1'b0;
      expect_v("hand_idle", S_OWNER, 32'd0);
      tick();

      // Round-robin from IDLE with both requesting
      bus.need_lock_0 = 1'b1;
      bus.need_lock_1 = 1'b1;
      expect_v("rr_first", S_OWNER, 32'd1);
      tick();
      bus.need_lock_0 = 1'b0;
      bus.need_lock_1 = 1'b0;
      expect_v("rr_idle1", S_OWNER, 32'd0);
      tick();
      bus.need_lock_0 = 1'b1;
      bus.need_lock_1 = 1'b1;
      expect_v("rr_second", S_OWNER, 32'd2);
      tick();
      bus.need_lock_0 = 1'b0;
      bus.need_lock_1 = 1'b0;
      expect_v("rr_idle2", S_OWNER, 32'd0);
      tick();

      // Lock-breaking write by core 1 while core 0 owns
      bus.need_lock_0 = 1'b1;
      expect_v("own0", S_OWNER, 32'd1);
      tick();
      bus.gwren_0    = 1'b1;
      bus.gaddress_0 = 6'd3;
      bus.gdata_0    = 32'hDEAD_BEEF;
      bus.gwren_1    = 1'b1;
      bus.gaddress_1 = 6'd5;
      bus.gdata_1    = 32'h1111_1111;
      expect_v("own0_wren_a", S_WREN_A, 32'd1);
      expect_v("own0_addr_a", S_ADDR_A, 32'd3);
      expect_v("own0_data_a", S_DATA_A, 32'hDEAD_BEEF);
      expect_v("own0_wren_b", S_WREN_B, 32'd0);
      expect_v("own0_addr_b", S_ADDR_B, 32'd5);
      expect_v("own0_vcnt", S_VCNT, 32'd1);
      tick();
      bus.gwren_0     = 1'b0;
      bus.gwren_1     = 1'b0;
      bus.need_lock_0 = 1'b0;
      expect_v("own0_wren_off", S_WREN_A, 32'd0);
      expect_v("own0_rel", S_OWNER, 32'd0);
      tick();

      // Same-address collision in IDLE, then distinct addresses
      bus.gwren_0    = 1'b1;
      bus.gwren_1    = 1'b1;
      bus.gaddress_0 = 6'd7;
      bus.gaddress_1 = 6'd7;
      bus.gdata_0    = 32'h0000_AAAA;
      bus.gdata_1    = 32'h0000_5555;
      expect_v("col_wren_a", S_WREN_A, 32'd1);
      expect_v("col_wren_b", S_WREN_B, 32'd0);
      expect_v("col_data_a", S_DATA_A, 32'h0000_AAAA);
      expect_v("col_data_b", S_DATA_B, 32'h0000_5555);
      expect_v("col_vcnt", S_VCNT, 32'd2);
      tick();
      bus.gaddress_1 = 6'd8;
      expect_v("nocol_wren_a", S_WREN_A, 32'd1);
      expect_v("nocol_wren_b", S_WREN_B, 32'd1);
      expect_v("nocol_addr_b", S_ADDR_B, 32'd8);
      expect_v("nocol_vcnt", S_VCNT, 32'd2);
      tick();
      bus.gwren_0 = 1'b0;
      bus.gwren_1 = 1'b0;
      expect_v("nocol_off_a", S_WREN_A, 32'd0);
      expect_v("nocol_off_b", S_WREN_B, 32'd0);
      tick();

      // Lock-breaking write by core 0 while core 1 owns
      bus.need_lock_1 = 1'b1;
      expect_v("own1", S_OWNER, 32'd2);
      tick();
      bus.gwren_0    = 1'b1;
      bus.gaddress_0 = 6'd4;
      expect_v("own1_wren_a", S_WREN_A, 32'd0);
      expect_v("own1_lock0", S_LOCK0, 32'd0);
      expect_v("own1_vcnt", S_VCNT, 32'd3);
      tick();
      bus.gwren_0     = 1'b0;
      bus.need_lock_1 = 1'b0;
      expect_v("own1_rel", S_OWNER, 32'd0);
      tick();

      // Hold timeout: counter is 0 in the grant cycle
      bus.need_lock_0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         expect_v("hold_owner", S_OWNER, 32'd1);
         expect_v("hold_hto", S_HTO, (i >= int'(HOLD_MAX)) ? 32'd1 : 32'd0);
         tick();
      end
      bus.need_lock_0 = 1'b0;
      expect_v("hold_rel_hto", S_HTO, 32'd0);
      expect_v("hold_rel_owner", S_OWNER, 32'd0);
      tick();

      // Violation counter saturation under a sustained lock-breaking writer
      bus.need_lock_0 = 1'b1;
      bus.gwren_1     = 1'b1;
      bus.gaddress_1  = 6'd9;
      expect_v("sat_grant", S_OWNER, 32'd1);
      expect_v("sat_grant_wren_b", S_WREN_B, 32'd1);
      expect_v("sat_grant_vcnt", S_VCNT, 32'd3);
      tick();
      repeat (250) tick();
      expect_v("sat_254", S_VCNT, 32'd254);
      expect_v("sat_wren_b", S_WREN_B, 32'd0);
      tick();
      expect_v("sat_255", S_VCNT, 32'd255);
      tick();
      expect_v("sat_hold", S_VCNT, 32'd255);
      expect_v("sat_hto", S_HTO, 32'd1);
      tick();

      // Reset in the middle of a grant
      rst = 1'b0;
      expect_v("mid_rst_owner", S_OWNER, 32'd0);
      expect_v("mid_rst_vcnt", S_VCNT, 32'd0);
      expect_v("mid_rst_wren_b", S_WREN_B, 32'd0);
      expect_v("mid_rst_addr_b", S_ADDR_B, 32'd0);
      expect_v("mid_rst_hto", S_HTO, 32'd0);
      expect_v("mid_rst_lock1", S_LOCK1, 32'd0);
      tick();
      rst             = 1'b1;
      bus.need_lock_0 = 1'b0;
      bus.gwren_1     = 1'b0;
      expect_v("post_rst_owner", S_OWNER, 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
